// File: rtl/readout_pkg.sv
// Shared definitions for the fill readout sequencer: FSM encoding and
// the marker bytes that tag header and trailer words.
package readout_pkg;

    localparam int         NCHAN_DEFAULT = 5;
    localparam logic [7:0] HDR_MARK      = 8'hF1;
    localparam logic [7:0] TRL_MARK      = 8'hF2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_READ    = 2'd2,
        ST_TRAILER = 2'd3
    } state_e;

endpackage

// File: rtl/lowest_bit_select.sv
// Priority encoder: isolates the lowest set bit of a vector as a one-hot
// word and flags when no bit is set at all.
module lowest_bit_select #(
    parameter int W = 5
) (
    input  logic [W-1:0] vec_i,
    output logic [W-1:0] onehot_o,
    output logic         none_o
);

    // Two's-complement trick keeps only the least significant one.
    assign onehot_o = vec_i & (~vec_i + W'(1));
    assign none_o   = ~(|vec_i);

endmodule

// File: rtl/readout_sequencer.sv
// Per-fill readout sequencer: pops one fill record, emits a header word,
// grants each enabled channel in ascending order, then emits a trailer.
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int NCHAN          = NCHAN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fifo_valid,
    input  logic [23:0]      fill_num,
    output logic             fifo_ready,
    input  logic [NCHAN-1:0] chan_enable,
    output logic [NCHAN-1:0] go,
    input  logic [NCHAN-1:0] done,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int          FW       = (NCHAN < 5) ? NCHAN : 5;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [23:0]      fill_q, fill_d;
    logic [NCHAN-1:0] en_q, en_d;
    logic [NCHAN-1:0] remaining_q, remaining_d;
    logic [NCHAN-1:0] cur_q, cur_d;
    logic [NCHAN-1:0] tmo_q, tmo_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [NCHAN-1:0] sel_onehot_s;
    logic             sel_none_s;
    logic             done_hit_s;
    logic             tmo_hit_s;
    logic [4:0]       en5_s;
    logic [4:0]       tmo5_s;

    // cur_q is zero outside READ, so this also yields the first channel in HEADER.
    lowest_bit_select #(.W(NCHAN)) u_next_chan (
        .vec_i    (remaining_q & ~cur_q),
        .onehot_o (sel_onehot_s),
        .none_o   (sel_none_s)
    );

    assign done_hit_s = |(done & cur_q);
    assign tmo_hit_s  = (cnt_q == TMO_LAST);
    assign en5_s      = 5'(en_q[FW-1:0]);
    assign tmo5_s     = 5'(tmo_q[FW-1:0]);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            fill_q      <= 24'd0;
            en_q        <= '0;
            remaining_q <= '0;
            cur_q       <= '0;
            tmo_q       <= '0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            en_q        <= en_d;
            remaining_q <= remaining_d;
            cur_q       <= cur_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        en_d        = en_q;
        remaining_d = remaining_q;
        cur_d       = cur_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_valid) begin
                    state_d     = ST_HEADER;
                    fill_d      = fill_num;
                    en_d        = chan_enable;
                    remaining_d = chan_enable;
                    cur_d       = '0;
                    tmo_d       = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (!out_ready) begin
                    state_d = ST_HEADER;
                end else if (sel_none_s) begin
                    state_d = ST_TRAILER;
                end else begin
                    state_d = ST_READ;
                    cur_d   = sel_onehot_s;
                    cnt_d   = 16'd0;
                end
            end
            ST_READ: begin
                if (done_hit_s || tmo_hit_s) begin
                    // A done arriving on the timeout cycle still counts as done.
                    if (!done_hit_s) begin
                        tmo_d = tmo_q | cur_q;
                    end else begin
                        tmo_d = tmo_q;
                    end
                    remaining_d = remaining_q & ~cur_q;
                    cnt_d       = 16'd0;
                    if (sel_none_s) begin
                        state_d = ST_TRAILER;
                        cur_d   = '0;
                    end else begin
                        state_d = ST_READ;
                        cur_d   = sel_onehot_s;
                    end
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_TRAILER: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else begin
                    state_d = ST_TRAILER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state, so they are glitch-free
    // and drop asynchronously with reset.
    always_comb begin
        fifo_ready = 1'b0;
        busy       = 1'b0;
        go         = '0;
        out_valid  = 1'b0;
        out_data   = 32'd0;
        case (state_q)
            ST_IDLE: begin
                fifo_ready = reset_n;
            end
            ST_HEADER: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = {HDR_MARK, fill_q};
            end
            ST_READ: begin
                busy = 1'b1;
                go   = cur_q;
            end
            ST_TRAILER: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = {TRL_MARK, 14'd0, en5_s, tmo5_s};
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer: directed scenarios plus
// randomized fills compared against a per-fill behavioural model.
module tb_readout_sequencer;

    localparam int NCH = 5;
    localparam int TO  = 16;

    logic           clk;
    logic           reset_n;
    logic           fifo_valid;
    logic [23:0]    fill_num;
    logic           fifo_ready;
    logic [NCH-1:0] chan_enable;
    logic [NCH-1:0] go;
    logic [NCH-1:0] done;
    logic           out_valid;
    logic [31:0]    out_data;
    logic           out_ready;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;
    int pop_cnt = 0;
    int dly [NCH];
    bit noise_en;

    readout_sequencer #(.NCHAN(NCH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fifo_valid  (fifo_valid),
        .fill_num    (fill_num),
        .fifo_ready  (fifo_ready),
        .chan_enable (chan_enable),
        .go          (go),
        .done        (done),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_valid && fifo_ready) pop_cnt <= pop_cnt + 1;
    end

    // {go, out_valid, out_data, busy, fifo_ready}
    function automatic logic [39:0] snap();
        return {go, out_valid, out_data, busy, fifo_ready};
    endfunction

    localparam logic [39:0] IDLE_V = 40'h00_0000_0001;

    // One complete fill; expectations derived from mask and per-channel done delays.
    task automatic run_fill(input logic [23:0] fn, input logic [4:0] mask,
                            input int hs, input int ts, input bit hold, input string nm);
        logic [39:0] exp_v, obs;
        logic [31:0] hdr, trl;
        logic [4:0]  tmo, oh, noise;
        int hi, p0;
        hdr = {8'hF1, fn};
        tmo = 5'd0;
        for (int c = 0; c < NCH; c++) if (mask[c] && dly[c] >= TO) tmo[c] = 1'b1;
        trl = {8'hF2, 14'd0, mask, tmo};
        p0  = pop_cnt;

        obs = snap(); n_cmp++;
        if (obs !== IDLE_V) begin n_err++; $display("FAIL %s idle: got %h expected %h", nm, obs, IDLE_V); end
        fifo_valid = 1'b1; fill_num = fn; chan_enable = mask; out_ready = 1'b0; done = '0;
        @(negedge clk);
        fifo_valid = hold; fill_num = 24'($urandom); chan_enable = 5'($urandom);

        exp_v = {5'd0, 1'b1, hdr, 1'b1, 1'b0};
        for (int s = 0; s <= hs; s++) begin
            obs = snap(); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL %s header s=%0d: got %h expected %h", nm, s, obs, exp_v); end
            out_ready = (s == hs);
            @(negedge clk);
        end
        out_ready = 1'b0;

        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                oh = 5'd1 << c;
                hi = (dly[c] >= TO) ? TO : dly[c] + 1;
                exp_v = {oh, 1'b0, 32'd0, 1'b1, 1'b0};
                for (int k = 0; k < hi; k++) begin
                    obs = snap(); n_cmp++;
                    if (obs !== exp_v) begin n_err++; $display("FAIL %s read ch%0d k=%0d: got %h expected %h", nm, c, k, obs, exp_v); end
                    noise = noise_en ? 5'($urandom) : 5'd0;
                    done = (noise & ~oh) | ((k == dly[c]) ? oh : 5'd0);
                    @(negedge clk);
                end
            end
        end
        done = '0;

        exp_v = {5'd0, 1'b1, trl, 1'b1, 1'b0};
        for (int s = 0; s <= ts; s++) begin
            obs = snap(); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL %s trailer s=%0d: got %h expected %h", nm, s, obs, exp_v); end
            out_ready = (s == ts);
            @(negedge clk);
        end
        out_ready = 1'b0; fifo_valid = 1'b0;

        obs = snap(); n_cmp++;
        if (obs !== IDLE_V) begin n_err++; $display("FAIL %s end idle: got %h expected %h", nm, obs, IDLE_V); end
        n_cmp++;
        if (pop_cnt - p0 !== 1) begin n_err++; $display("FAIL %s pops: got %0d expected 1", nm, pop_cnt - p0); end
    endtask

    task automatic test_reset();
        logic [39:0] obs;
        reset_n = 1'b0; fifo_valid = 1'b1; fill_num = 24'hABCDEF; chan_enable = 5'h1F;
        done = '0; out_ready = 1'b1; noise_en = 1'b0;
        repeat (3) @(negedge clk);
        obs = snap(); n_cmp++;
        if (obs !== 40'd0) begin n_err++; $display("FAIL reset: got %h expected %h", obs, 40'd0); end
        n_cmp++;
        if (pop_cnt !== 0) begin n_err++; $display("FAIL reset pops: got %0d expected 0", pop_cnt); end
        fifo_valid = 1'b0; out_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        obs = snap(); n_cmp++;
        if (obs !== IDLE_V) begin n_err++; $display("FAIL reset release: got %h expected %h", obs, IDLE_V); end
    endtask

    task automatic test_spec_example();
        for (int c = 0; c < NCH; c++) dly[c] = 3;
        run_fill(24'h000123, 5'b10101, 0, 0, 1'b0, "example");
    endtask

    task automatic test_empty_mask();
        for (int c = 0; c < NCH; c++) dly[c] = 0;
        run_fill(24'h55AA55, 5'b00000, 0, 0, 1'b0, "empty");
    endtask

    task automatic test_timeout();
        dly[0] = 2; dly[1] = 255;
        run_fill(24'h000777, 5'b00011, 0, 2, 1'b0, "timeout");
        // Done on the last countable cycle must win over the timeout.
        dly[0] = TO - 1; dly[3] = TO;
        run_fill(24'h0A0B0C, 5'b01001, 1, 0, 1'b0, "tie");
    endtask

    task automatic test_header_stall();
        dly[2] = 1; dly[4] = 0;
        run_fill(24'hFEDCBA, 5'b10100, 10, 0, 1'b0, "hdr_stall");
    endtask

    task automatic test_reset_mid_fill();
        logic [39:0] obs;
        int p0;
        fifo_valid = 1'b1; fill_num = 24'h123456; chan_enable = 5'b00110;
        @(negedge clk);
        fifo_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        obs = snap(); n_cmp++;
        if (obs !== 40'd0) begin n_err++; $display("FAIL midreset async: got %h expected %h", obs, 40'd0); end
        p0 = pop_cnt;
        fifo_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        obs = snap(); n_cmp++;
        if (obs !== 40'd0) begin n_err++; $display("FAIL midreset held: got %h expected %h", obs, 40'd0); end
        n_cmp++;
        if (pop_cnt !== p0) begin n_err++; $display("FAIL midreset pops: got %0d expected %0d", pop_cnt, p0); end
        fifo_valid = 1'b0; out_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        dly[1] = 1; dly[2] = 4;
        run_fill(24'h654321, 5'b00110, 0, 1, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        noise_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < NCH; c++) dly[c] = $urandom_range(0, 5);
            run_fill(24'($urandom), 5'($urandom_range(1, 31)), 0, 0, 1'b1, "b2b");
        end
    endtask

    task automatic test_random();
        noise_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            for (int c = 0; c < NCH; c++) dly[c] = $urandom_range(0, 20);
            run_fill(24'($urandom), 5'($urandom_range(0, 31)),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_spec_example();
        test_empty_mask();
        test_timeout();
        test_header_stall();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 Parameter NCHAN, default 5: number of channels sequenced.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: maximum cycles to wait for a channel's done.
REQ-003 clk  in  1  the single clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 fifo_valid  in  1  a fill record is available.
REQ-006 fill_num  in  24  fill number of the offered record.
REQ-007 fifo_ready  out  1  pop strobe; a transfer occurs when fifo_valid and fifo_ready are both high.
REQ-008 chan_enable  in  NCHAN  channel readout mask; sampled only at pop.
REQ-009 go  out  NCHAN  one-hot (or zero) readout grant per channel.
REQ-010 done  in  NCHAN  channel finished its readout.
REQ-011 out_valid  out  1  header/trailer word valid.
REQ-012 out_data  out  32  header/trailer word.
REQ-013 out_ready  in  1  downstream accepts the word.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, HEADER, READ and TRAILER.
REQ-016 IDLE: fifo_ready=1; on a transfer, latch fill_num and chan_enable and go to HEADER on the next cycle.
REQ-017 In HEADER the block SHALL drive out_valid=1 and out_data={8'hF1, fill_num_latched}, held stable until out_ready.
REQ-018 On header acceptance: if the latched mask is nonzero, go to READ on the lowest set bit; otherwise go to TRAILER.
REQ-019 READ: go SHALL be one-hot on the current channel; the wait counter SHALL clear on every READ entry.
REQ-020 READ exit condition: done[cur]=1, or the counter reaching TIMEOUT_CYCLES-1 (then set timeout_mask[cur]).
REQ-021 On READ exit the block SHALL clear cur from the remaining mask.
REQ-022 After READ exit, the next cycle's go SHALL move directly to the next lowest remaining channel, with no idle cycle; if none remain, go to TRAILER.
REQ-023 TRAILER: out_data={8'hF2, 14'd0, enable_latched[4:0], timeout_mask[4:0]} with out_valid=1; on out_ready go to IDLE and clear timeout_mask.
REQ-024 done on a non-selected channel SHALL be ignored.
REQ-025 done and timeout in the same cycle: done wins and no timeout bit is set.
REQ-026 chan_enable changes after pop SHALL have no effect on the current fill.
REQ-027 fifo_ready SHALL be 0 in all states except IDLE; records arriving while busy are held off, never lost.
REQ-028 out_valid SHALL never deassert without out_ready, and out_data SHALL not change while out_valid=1 and out_ready=0.
REQ-029 Timing: pop at cycle N gives out_valid at N+1; header accepted at cycle H gives go at H+1; done at cycle M drops go[cur] at M+1.
REQ-030 The counter SHALL be 16 bits wide and saturating; TIMEOUT_CYCLES SHALL be at least 2.

Reset
REQ-031 reset_n low SHALL immediately force state=IDLE and go=0, out_valid=0, out_data=0, busy=0, fifo_ready=0 (while asserted), and clear all latched registers, counter and timeout_mask.
REQ-032 A reset mid-fill SHALL abandon the fill; no trailer is emitted and no FIFO record is popped during reset.
REQ-033 The first pop is possible in the cycle after reset_n deasserts.

Structure
REQ-034 A shared package readout_pkg SHALL hold: the state encoding, the HDR_MARK=8'hF1 and TRL_MARK=8'hF2 constants, and the NCHAN default.
REQ-035 One sub-module, lowest_bit_select, SHALL be a parameterised priority encoder returning the one-hot lowest set bit plus a none flag, used to pick the next channel.

Verification
REQ-036 Scenario: fill_num=24'h000123, mask=5'b10101, each done 3 cycles after go -> header 32'hF1000123, go order 00001, 00100, 10000, trailer 32'hF20002A0.
REQ-037 Scenario: mask=0 -> header immediately followed by trailer 32'hF2000000; go stays 0 throughout.
REQ-038 Scenario: TIMEOUT_CYCLES=16, mask=5'b00011, channel 1 never done -> go[1] high for 16 cycles, trailer 32'hF2000062.
REQ-039 Scenario: out_ready low for 10 cycles on the header -> out_data stable, go=0 until acceptance.
REQ-040 Scenario: reset_n pulsed low in READ -> go=0 asynchronously, busy=0; a subsequent fill proceeds normally.
REQ-041 Scenario: fifo_valid held high while busy -> exactly one pop per fill; done pulsed on a non-selected channel is ignored.
